multi_clock_enable_gen: RTL

// - Synthesizable, parametrised successor to the free-running bench clock toggle.
// - Generates NUM_CH independent clock-enable strobes (tick) and 50%-duty toggles (tog) from sys_clock.
// - Each channel has a programmable divider and a free-run or counted-burst mode.
// - Paces nonce-sweep and hash-pipeline stages inside the miner block design, and drives stimulus in benches.

---
 rtl/clk_en_pkg.sv | 28 ++
 rtl/clk_en_channel.sv | 113 +++++++++++
 rtl/multi_clock_enable_gen.sv | 68 ++++++
 3 files changed

// File: rtl/clk_en_pkg.sv
// Shared types for the multi-channel clock-enable generator.
package clk_en_pkg;

    localparam int unsigned CFG_DIV_W   = 16;
    localparam int unsigned CFG_BURST_W = 8;

    typedef enum logic [1:0] {
        MODE_FREE  = 2'd0,
        MODE_BURST = 2'd1
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef struct packed {
        logic [CFG_DIV_W-1:0]   div;
        mode_e                  mode;
        logic [CFG_BURST_W-1:0] burst;
    } chan_cfg_t;

    // Reserved mode encodings fall back to free-running.
    function automatic mode_e decode_mode(input logic [1:0] m);
        return (m == 2'd1) ? MODE_BURST : MODE_FREE;
    endfunction

endpackage

// File: rtl/clk_en_channel.sv
// One clock-enable channel: run/idle FSM, divider counter and burst counter.
module clk_en_channel
    import clk_en_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  chan_cfg_t cfg,
    input  logic      start,
    input  logic      stop,
    output logic      tick,
    output logic      tog,
    output logic      busy,
    output logic      done
);

    state_e                 state_q, state_d;
    logic [CFG_DIV_W-1:0]   cnt_q, cnt_d;
    logic [CFG_DIV_W-1:0]   div_q, div_d;
    logic [CFG_BURST_W-1:0] rem_q, rem_d;
    logic                   burst_mode_q, burst_mode_d;
    logic                   tick_q, tick_d;
    logic                   tog_q, tog_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic                   empty_burst_c;
    logic                   first_tick_c;
    logic [CFG_DIV_W-1:0]   cnt_nxt_c;
    logic                   run_tick_c;

    // A zero-length burst completes immediately without entering RUN.
    assign empty_burst_c = (cfg.mode == MODE_BURST) && (cfg.burst == '0);
    // div=0 ticks in the very first cycle after start.
    assign first_tick_c  = (state_d == ST_RUN) && (cfg.div == '0);
    assign cnt_nxt_c     = (cnt_q == div_q) ? '0 : cnt_q + CFG_DIV_W'(1);
    assign run_tick_c    = (cnt_nxt_c == div_q);

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            div_q        <= '0;
            rem_q        <= '0;
            burst_mode_q <= 1'b0;
            tick_q       <= 1'b0;
            tog_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            div_q        <= div_d;
            rem_q        <= rem_d;
            burst_mode_q <= burst_mode_d;
            tick_q       <= tick_d;
            tog_q        <= tog_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    // Next state: stop beats start, start beats burst completion.
    always_comb begin
        state_d = state_q;
        if (stop) begin
            state_d = ST_IDLE;
        end else if (start) begin
            state_d = empty_burst_c ? ST_IDLE : ST_RUN;
        end else if ((state_q == ST_RUN) && done_q) begin
            state_d = ST_IDLE;
        end
    end

    // Counters and registered outputs for the coming cycle.
    always_comb begin
        cnt_d        = cnt_q;
        div_d        = div_q;
        rem_d        = rem_q;
        burst_mode_d = burst_mode_q;
        tick_d       = 1'b0;
        tog_d        = tog_q;
        done_d       = 1'b0;
        busy_d       = (state_d == ST_RUN);
        if (stop) begin
            cnt_d = cnt_q;
        end else if (start) begin
            div_d        = cfg.div;
            burst_mode_d = (cfg.mode == MODE_BURST);
            cnt_d        = '0;
            tick_d       = first_tick_c;
            tog_d        = first_tick_c;
            rem_d        = cfg.burst - CFG_BURST_W'(first_tick_c);
            done_d       = (cfg.mode == MODE_BURST) &&
                           (empty_burst_c ||
                            (first_tick_c && (cfg.burst == CFG_BURST_W'(1))));
        end else if ((state_q == ST_RUN) && !done_q) begin
            cnt_d  = cnt_nxt_c;
            tick_d = run_tick_c;
            tog_d  = tog_q ^ run_tick_c;
            if (burst_mode_q && run_tick_c) begin
                rem_d  = rem_q - CFG_BURST_W'(1);
                done_d = (rem_q == CFG_BURST_W'(1));
            end
        end
    end

    assign tick = tick_q;
    assign tog  = tog_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: rtl/multi_clock_enable_gen.sv
// NUM_CH independent clock-enable channels with per-channel shadow configuration.
module multi_clock_enable_gen
    import clk_en_pkg::*;
#(
    parameter  int unsigned NUM_CH  = 4,
    parameter  int unsigned DIV_W   = CFG_DIV_W,
    parameter  int unsigned BURST_W = CFG_BURST_W,
    localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic               sys_clock,
    input  logic               resetn,
    input  logic               cfg_wr,
    input  logic [CH_W-1:0]    cfg_ch,
    input  logic [DIV_W-1:0]   cfg_div,
    input  logic [1:0]         cfg_mode,
    input  logic [BURST_W-1:0] cfg_burst,
    input  logic [NUM_CH-1:0]  start,
    input  logic [NUM_CH-1:0]  stop,
    output logic [NUM_CH-1:0]  tick,
    output logic [NUM_CH-1:0]  tog,
    output logic [NUM_CH-1:0]  busy,
    output logic [NUM_CH-1:0]  done
);

    chan_cfg_t shadow_q [NUM_CH];
    chan_cfg_t shadow_d [NUM_CH];
    chan_cfg_t wr_cfg_c;

    assign wr_cfg_c = '{div:   CFG_DIV_W'(cfg_div),
                        mode:  decode_mode(cfg_mode),
                        burst: CFG_BURST_W'(cfg_burst)};

    // Shadow write decode; the written value is visible to a same-edge start.
    always_comb begin
        for (int i = 0; i < int'(NUM_CH); i++) begin
            shadow_d[i] = shadow_q[i];
            if (cfg_wr && (cfg_ch == CH_W'(i))) begin
                shadow_d[i] = wr_cfg_c;
            end
        end
    end

    // Shadow configuration registers.
    always_ff @(posedge sys_clock) begin
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (!resetn) begin
                shadow_q[i] <= '0;
            end else begin
                shadow_q[i] <= shadow_d[i];
            end
        end
    end

    for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_ch
        clk_en_channel u_ch (
            .clk   (sys_clock),
            .rst_n (resetn),
            .cfg   (shadow_d[g]),
            .start (start[g]),
            .stop  (stop[g]),
            .tick  (tick[g]),
            .tog   (tog[g]),
            .busy  (busy[g]),
            .done  (done[g])
        );
    end

endmodule
